// File: rtl/count10000_pkg.sv
// Shared definitions for the 0..9999 run/stop counter: state encoding,
// count width and the default terminal value.
package count10000_pkg;

  localparam int COUNT_W           = 14;
  localparam int MAX_COUNT_DEFAULT = 9999;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/count10000_ctrl_tick_gen.sv
// Step-rate divider: counts 0..TICK_DIV-1 while enabled and raises tick
// while it sits on its last value; disabling it discards the phase.
module tick_gen #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int               DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] LAST  = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = '0;
    if (enable && (div_q != LAST)) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == LAST);

endmodule

// File: rtl/count10000_ctrl.sv
// Run/stop/clear controller for a wrapping up/down counter stepped by the
// tick_gen divider; every output comes straight from a register.
module count10000_ctrl
  import count10000_pkg::*;
#(
  parameter int TICK_DIV  = 10_000_000,
  parameter int MAX_COUNT = MAX_COUNT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_run_stop,
  input  logic               i_clear,
  input  logic               i_mode,
  output logic [COUNT_W-1:0] o_count,
  output logic               o_run,
  output logic               o_mode,
  output logic               o_tick
);

  localparam logic [COUNT_W-1:0] MAX_VAL = COUNT_W'(MAX_COUNT);

  state_e             state_q;
  state_e             state_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;
  logic               mode_q;
  logic               mode_d;
  logic               run_q;
  logic               run_d;
  logic               tick_q;
  logic               tick_d;
  logic               div_tick;
  logic               div_enable;
  logic               step;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      STOP: begin
        if (i_clear) begin
          state_d = CLEAR;
        end else if (i_run_stop) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_clear) begin
          state_d = CLEAR;
        end else if (i_run_stop) begin
          state_d = STOP;
        end
      end
      CLEAR:   state_d = STOP;
      default: state_d = STOP;
    endcase
  end

  // The divider only advances across RUN->RUN edges, so it restarts from 0
  // on RUN entry and is cleared on the edge that leaves RUN.
  assign div_enable = (state_q == RUN) && (state_d == RUN);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .enable (div_enable),
    .tick   (div_tick)
  );

  // A step on the stopping edge still commits; a coinciding clear wins.
  assign step = (state_q == RUN) && div_tick && !i_clear;

  always_comb begin
    count_d = count_q;
    if (state_d == CLEAR) begin
      count_d = '0;
    end else if (step) begin
      if (mode_q) begin
        count_d = (count_q == '0) ? MAX_VAL : count_q - COUNT_W'(1);
      end else begin
        count_d = (count_q >= MAX_VAL) ? '0 : count_q + COUNT_W'(1);
      end
    end
    mode_d = mode_q ^ i_mode;
    run_d  = (state_d == RUN);
    tick_d = step;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= STOP;
      count_q <= '0;
      mode_q  <= 1'b0;
      run_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      run_q   <= run_d;
      tick_q  <= tick_d;
    end
  end

  assign o_count = count_q;
  assign o_run   = run_q;
  assign o_mode  = mode_q;
  assign o_tick  = tick_q;

endmodule

// File: tb/tb_count10000_ctrl.sv
// Directed bench for count10000_ctrl with TICK_DIV=4: expected steps (value
// and edge number) are queued when stimulus is applied and checked on o_tick.
module tb_count10000_ctrl;

  localparam int TICK_DIV = 4;
  localparam int MAXC     = 9999;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_run_stop;
  logic        i_clear;
  logic        i_mode;
  logic [13:0] o_count;
  logic        o_run;
  logic        o_mode;
  logic        o_tick;

  typedef struct {
    int cnt;
    int cyc;
  } exp_t;

  exp_t sbQ[$];
  int   cycleCnt   = 0;
  int   compared   = 0;
  int   mismatched = 0;

  count10000_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .MAX_COUNT (MAXC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_run_stop (i_run_stop),
    .i_clear    (i_clear),
    .i_mode     (i_mode),
    .o_count    (o_count),
    .o_run      (o_run),
    .o_mode     (o_mode),
    .o_tick     (o_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse the given inputs across exactly one rising edge.
  task automatic applyStimulus(input logic rs, input logic clr, input logic md);
    i_run_stop = rs;
    i_clear    = clr;
    i_mode     = md;
    @(posedge clk);
    #1;
    i_run_stop = 1'b0;
    i_clear    = 1'b0;
    i_mode     = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue n expected steps starting from value v, k-th one on edge base+4k.
  task automatic pushSteps(input int base, input int startVal, input bit down, input int n);
    int v;
    exp_t e;
    v = startVal;
    for (int k = 1; k <= n; k++) begin
      if (down) v = (v == 0) ? MAXC : v - 1;
      else      v = (v == MAXC) ? 0 : v + 1;
      e.cnt = v;
      e.cyc = base + TICK_DIV * k;
      sbQ.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (o_tick !== 1'b0) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $error("[TB] FAIL unexpectedTick: observed tick with count %0d at edge %0d expected no tick",
               o_count, cycleCnt);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput("tickCount", 32'(o_count), 32'(e.cnt));
        checkOutput("tickEdge", 32'(cycleCnt), 32'(e.cyc));
      end
    end
  end

  initial begin
    int n;

    // Reset with pulses asserted: they must be ignored.
    rst        = 1'b0;
    i_run_stop = 1'b1;
    i_clear    = 1'b0;
    i_mode     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstCount", 32'(o_count), 0);
    checkOutput("rstRun", 32'(o_run), 0);
    checkOutput("rstMode", 32'(o_mode), 0);
    checkOutput("rstTick", 32'(o_tick), 0);
    i_run_stop = 1'b0;
    i_mode     = 1'b0;
    rst        = 1'b1;
    waitCycles(1);
    checkOutput("idleRun", 32'(o_run), 0);

    // Count up 10 steps.
    applyStimulus(1, 0, 0);
    n = cycleCnt;
    pushSteps(n, 0, 0, 10);
    checkOutput("runEntry", 32'(o_run), 1);
    waitCycles(40);
    checkOutput("count10", 32'(o_count), 10);

    // Clear from RUN, then simultaneous clear + run_stop at count 7.
    applyStimulus(0, 1, 0);
    checkOutput("clearCycleCount", 32'(o_count), 0);
    checkOutput("clearCycleRun", 32'(o_run), 0);
    waitCycles(1);
    applyStimulus(1, 0, 0);
    n = cycleCnt;
    pushSteps(n, 0, 0, 7);
    waitCycles(28);
    checkOutput("count7", 32'(o_count), 7);
    applyStimulus(0, 0, 1);
    checkOutput("modeToggle", 32'(o_mode), 1);
    applyStimulus(1, 1, 0);
    checkOutput("simulCount", 32'(o_count), 0);
    checkOutput("simulRun", 32'(o_run), 0);
    checkOutput("simulMode", 32'(o_mode), 1);
    waitCycles(1);
    checkOutput("afterClearRun", 32'(o_run), 0);
    waitCycles(8);
    checkOutput("stayStopCount", 32'(o_count), 0);
    checkOutput("stayStopRun", 32'(o_run), 0);
    applyStimulus(0, 0, 1);
    checkOutput("modeInStop", 32'(o_mode), 0);

    // Stop with divider at 2, resume: phase must be discarded.
    applyStimulus(1, 0, 0);
    n = cycleCnt;
    pushSteps(n, 0, 0, 3);
    waitCycles(14);
    applyStimulus(1, 0, 0);
    checkOutput("stopRun", 32'(o_run), 0);
    checkOutput("stopCount", 32'(o_count), 3);
    waitCycles(5);
    checkOutput("heldCount", 32'(o_count), 3);
    applyStimulus(1, 0, 0);
    n = cycleCnt;
    pushSteps(n, 3, 0, 1);
    waitCycles(4);
    checkOutput("resumeCount", 32'(o_count), 4);
    checkOutput("resumeRun", 32'(o_run), 1);

    // Stop on a step edge: the step still commits.
    waitCycles(3);
    pushSteps(n + TICK_DIV, 4, 0, 1);
    applyStimulus(1, 0, 0);
    checkOutput("stopStepCount", 32'(o_count), 5);
    checkOutput("stopStepTick", 32'(o_tick), 1);
    checkOutput("stopStepRun", 32'(o_run), 0);

    // Clear on a step edge: the step is discarded.
    applyStimulus(1, 0, 0);
    waitCycles(3);
    applyStimulus(0, 1, 0);
    checkOutput("clearStepCount", 32'(o_count), 0);
    checkOutput("clearStepTick", 32'(o_tick), 0);
    waitCycles(1);

    // Down wrap from 0.
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    n = cycleCnt;
    pushSteps(n, 0, 1, 2);
    waitCycles(4);
    checkOutput("downWrap", 32'(o_count), 9999);
    waitCycles(4);
    checkOutput("down9998", 32'(o_count), 9998);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("clearKeepsMode", 32'(o_mode), 1);
    waitCycles(1);
    applyStimulus(0, 0, 1);

    // Mode pulse on a step edge uses the old direction.
    applyStimulus(1, 0, 0);
    n = cycleCnt;
    pushSteps(n, 0, 0, 1);
    waitCycles(3);
    applyStimulus(0, 0, 1);
    checkOutput("modeEdgeCount", 32'(o_count), 1);
    checkOutput("modeEdgeMode", 32'(o_mode), 1);
    pushSteps(n + TICK_DIV, 1, 1, 2);
    waitCycles(8);
    checkOutput("modeEdgeWrap", 32'(o_count), 9999);

    // Reset in RUN, down mode, count 5.
    applyStimulus(0, 1, 0);
    waitCycles(1);
    applyStimulus(0, 0, 1);
    applyStimulus(1, 0, 0);
    n = cycleCnt;
    pushSteps(n, 0, 0, 5);
    waitCycles(20);
    applyStimulus(0, 0, 1);
    checkOutput("preRstCount", 32'(o_count), 5);
    checkOutput("preRstMode", 32'(o_mode), 1);
    rst        = 1'b0;
    i_run_stop = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midRstCount", 32'(o_count), 0);
    checkOutput("midRstRun", 32'(o_run), 0);
    checkOutput("midRstMode", 32'(o_mode), 0);
    checkOutput("midRstTick", 32'(o_tick), 0);
    rst        = 1'b1;
    i_run_stop = 1'b0;
    waitCycles(1);
    checkOutput("postRstRun", 32'(o_run), 0);

    // Full up wrap: 10000 steps return to 0.
    applyStimulus(1, 0, 0);
    n = cycleCnt;
    pushSteps(n, 0, 0, 10000);
    waitCycles(40000);
    checkOutput("upWrap", 32'(o_count), 0);
    checkOutput("upWrapRun", 32'(o_run), 1);
    applyStimulus(1, 0, 0);
    waitCycles(2);
    checkOutput("pendingSteps", 32'(sbQ.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
